// File: rtl/wb_scoreboard_arbiter.sv
// wb_scoreboard_arbiter: pending-write scoreboard with round-robin writeback arbitration onto the register file
module wb_scoreboard_arbiter #(
   parameter int NUM_WB = 3,
   parameter int xlen = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   iss_valid,
   input  logic                   iss_rs1_valid,
   input  logic [4:0]             iss_rs1,
   input  logic                   iss_rs2_valid,
   input  logic [4:0]             iss_rs2,
   input  logic                   iss_rd_valid,
   input  logic [4:0]             iss_rd,
   output logic                   iss_ready,
   input  logic [NUM_WB-1:0]      wb_valid,
   input  logic [NUM_WB*5-1:0]    wb_ad,
   input  logic [NUM_WB*xlen-1:0] wb_data,
   output logic [NUM_WB-1:0]      wb_ready,
   output logic                   rf_w_valid,
   output logic [4:0]             rf_w_ad,
   output logic [xlen-1:0]        rf_w_data,
   output logic [31:0]            pend_o
);
   localparam int PW = $clog2(NUM_WB);
   logic [31:0]         pend;
   logic [PW-1:0]       rr_ptr;
   logic [PW-1:0]       off;
   logic [PW-1:0]       gnt_idx;
   logic [PW:0]         sum;
   logic                gnt_any;
   logic [2*NUM_WB-1:0] dbl;
   logic [4:0]          gnt_ad;
   logic [31:0]         set_mask;
   logic [31:0]         clr_mask;
   assign pend_o = pend;
   // Hazard check uses registered pend only, so a clearing writeback is not bypassed
   assign iss_ready = !flush && !(iss_rs1_valid && pend[iss_rs1]) && !(iss_rs2_valid && pend[iss_rs2]) && !(iss_rd_valid && pend[iss_rd]);
   // Round-robin search: rotate requests so rr_ptr lands at bit 0, take the lowest set bit, map back
   always_comb begin
      dbl = {wb_valid, wb_valid} >> rr_ptr;
      gnt_any = 1'b0;
      off = '0;
      for (int k = NUM_WB - 1; k >= 0; k--) begin
         if (dbl[k]) begin
            gnt_any = 1'b1;
            off = PW'(k);
         end
      end
      sum = {1'b0, rr_ptr} + {1'b0, off};
      gnt_idx = (sum >= (PW+1)'(NUM_WB)) ? PW'(sum - (PW+1)'(NUM_WB)) : PW'(sum);
   end
   assign wb_ready = gnt_any ? (NUM_WB'(1) << gnt_idx) : '0;
   assign gnt_ad = wb_ad[5*gnt_idx +: 5];
   assign set_mask = (iss_valid && iss_ready && iss_rd_valid) ? (32'd1 << iss_rd) : 32'd0;
   assign clr_mask = gnt_any ? (32'd1 << gnt_ad) : 32'd0;
   // Scoreboard, arbitration pointer and registered register-file write port
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend <= '0;
         rr_ptr <= '0;
         rf_w_valid <= 1'b0;
         rf_w_ad <= '0;
         rf_w_data <= '0;
      end else begin
         pend <= flush ? 32'd0 : (((pend & ~clr_mask) | set_mask) & ~32'd1);
         rf_w_valid <= gnt_any;
         if (gnt_any) begin
            rr_ptr <= (gnt_idx == PW'(NUM_WB - 1)) ? '0 : gnt_idx + 1'b1;
            rf_w_ad <= gnt_ad;
            rf_w_data <= wb_data[xlen*gnt_idx +: xlen];
         end
      end
   end
endmodule

// File: tb/tb_wb_scoreboard_arbiter.sv
// tb_wb_scoreboard_arbiter: directed checks of scoreboard hazards, round-robin grants and flush/reset behaviour
module tb_wb_scoreboard_arbiter;
   logic        clk = 1'b0;
   logic        rst_n, flush, iss_valid, iss_rs1_valid, iss_rs2_valid, iss_rd_valid;
   logic [4:0]  iss_rs1, iss_rs2, iss_rd;
   logic        iss_ready;
   logic [2:0]  wb_valid, wb_ready;
   logic [14:0] wb_ad;
   logic [95:0] wb_data;
   logic        rf_w_valid;
   logic [4:0]  rf_w_ad;
   logic [31:0] rf_w_data, pend_o;
   int checks = 0;
   int failures = 0;

   wb_scoreboard_arbiter #(.NUM_WB(3), .xlen(32)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .iss_valid(iss_valid), .iss_rs1_valid(iss_rs1_valid), .iss_rs1(iss_rs1),
      .iss_rs2_valid(iss_rs2_valid), .iss_rs2(iss_rs2), .iss_rd_valid(iss_rd_valid), .iss_rd(iss_rd),
      .iss_ready(iss_ready), .wb_valid(wb_valid), .wb_ad(wb_ad), .wb_data(wb_data), .wb_ready(wb_ready),
      .rf_w_valid(rf_w_valid), .rf_w_ad(rf_w_ad), .rf_w_data(rf_w_data), .pend_o(pend_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_wb(input int i, input logic [4:0] ad, input logic [31:0] d);
      wb_ad[5*i +: 5] = ad;
      wb_data[32*i +: 32] = d;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; iss_valid = 1'b0;
      iss_rs1_valid = 1'b0; iss_rs2_valid = 1'b0; iss_rd_valid = 1'b0;
      iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;
      wb_valid = '0; wb_ad = '0; wb_data = '0;
      #1;
      tick();
      tick();
      chk("reset_pend", 64'(pend_o), 64'd0);
      chk("reset_rf_valid", 64'(rf_w_valid), 64'd0);
      chk("reset_rf_ad", 64'(rf_w_ad), 64'd0);
      chk("reset_rf_data", 64'(rf_w_data), 64'd0);
      rst_n = 1'b1;
      iss_rs1_valid = 1'b1; iss_rs1 = 5'd5;
      iss_rs2_valid = 1'b1; iss_rs2 = 5'd6;
      iss_rd_valid = 1'b1; iss_rd = 5'd7;
      #1;
      chk("idle_iss_ready", 64'(iss_ready), 64'd1);
      chk("idle_wb_ready", 64'(wb_ready), 64'd0);
      tick();
      chk("idle_no_write", 64'(rf_w_valid), 64'd0);

      // issue rd=7 then a RAW reader of x7 stalls until source 1 writes it back
      iss_valid = 1'b1; iss_rs1_valid = 1'b0; iss_rs2_valid = 1'b0;
      tick();
      chk("issue_rd7_pend", 64'(pend_o), 64'h80);
      iss_rs1_valid = 1'b1; iss_rs1 = 5'd7; iss_rd_valid = 1'b0;
      #1;
      chk("raw_stall", 64'(iss_ready), 64'd0);
      iss_valid = 1'b0;
      iss_rs1_valid = 1'b0; iss_rd_valid = 1'b1;
      #1;
      chk("waw_stall", 64'(iss_ready), 64'd0);
      iss_rs1_valid = 1'b1; iss_rd_valid = 1'b0;
      set_wb(1, 5'd7, 32'hDEADBEEF);
      wb_valid = 3'b010;
      #1;
      chk("wb1_grant", 64'(wb_ready), 64'b010);
      tick();
      wb_valid = 3'b000;
      #1;
      chk("wb1_rf_valid", 64'(rf_w_valid), 64'd1);
      chk("wb1_rf_ad", 64'(rf_w_ad), 64'd7);
      chk("wb1_rf_data", 64'(rf_w_data), 64'hDEADBEEF);
      chk("wb1_pend_clear", 64'(pend_o), 64'd0);
      chk("wb1_iss_ready", 64'(iss_ready), 64'd1);
      iss_rs1_valid = 1'b0;

      // round robin from reset: all three sources requesting continuously
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      set_wb(0, 5'd10, 32'hA0A0_0000);
      set_wb(1, 5'd11, 32'hB1B1_1111);
      set_wb(2, 5'd12, 32'hC2C2_2222);
      wb_valid = 3'b111;
      for (int c = 0; c < 6; c++) begin
         #1;
         chk($sformatf("rr_grant_%0d", c), 64'(wb_ready), 64'(3'b001 << (c % 3)));
         tick();
         chk($sformatf("rr_ad_%0d", c), 64'(rf_w_ad), 64'(10 + c % 3));
         chk($sformatf("rr_valid_%0d", c), 64'(rf_w_valid), 64'd1);
      end
      chk("rr_data_last", 64'(rf_w_data), 64'hC2C2_2222);
      wb_valid = 3'b000;
      tick();
      chk("nogrant_valid", 64'(rf_w_valid), 64'd0);
      chk("nogrant_ad_hold", 64'(rf_w_ad), 64'd12);
      chk("nogrant_data_hold", 64'(rf_w_data), 64'hC2C2_2222);

      // x0 never becomes pending
      iss_valid = 1'b1; iss_rd_valid = 1'b1; iss_rd = 5'd0;
      iss_rs1_valid = 1'b1; iss_rs1 = 5'd0;
      #1;
      chk("x0_ready_first", 64'(iss_ready), 64'd1);
      tick();
      chk("x0_pend", 64'(pend_o), 64'd0);
      chk("x0_ready_again", 64'(iss_ready), 64'd1);
      tick();
      chk("x0_pend_again", 64'(pend_o), 64'd0);
      iss_rs1_valid = 1'b0;

      // issue rd=3, rd=9, then flush while source 0 writes x3
      iss_rd = 5'd3;
      tick();
      iss_rd = 5'd9;
      tick();
      chk("pre_flush_pend", 64'(pend_o), 64'h208);
      flush = 1'b1;
      iss_rd = 5'd5;
      set_wb(0, 5'd3, 32'h3333_3333);
      wb_valid = 3'b001;
      #1;
      chk("flush_iss_ready", 64'(iss_ready), 64'd0);
      chk("flush_wb_grant", 64'(wb_ready), 64'b001);
      tick();
      flush = 1'b0; wb_valid = 3'b000; iss_valid = 1'b0;
      #1;
      chk("flush_pend", 64'(pend_o), 64'd0);
      chk("flush_rf_valid", 64'(rf_w_valid), 64'd1);
      chk("flush_rf_ad", 64'(rf_w_ad), 64'd3);
      chk("flush_rf_data", 64'(rf_w_data), 64'h3333_3333);

      // issue-set and writeback-clear of x4 in one cycle: set wins (rr_ptr now 1)
      iss_valid = 1'b1; iss_rd_valid = 1'b1; iss_rd = 5'd4;
      set_wb(1, 5'd4, 32'h4444_4444);
      wb_valid = 3'b010;
      #1;
      chk("setwin_ready", 64'(iss_ready), 64'd1);
      chk("setwin_grant", 64'(wb_ready), 64'b010);
      tick();
      iss_valid = 1'b0; wb_valid = 3'b000;
      #1;
      chk("setwin_pend", 64'(pend_o), 64'h10);
      chk("setwin_rf_ad", 64'(rf_w_ad), 64'd4);

      // reset while all sources request: write dropped, pointer back to source 0
      set_wb(0, 5'd20, 32'h2020_2020);
      set_wb(1, 5'd21, 32'h2121_2121);
      set_wb(2, 5'd22, 32'h2222_2222);
      wb_valid = 3'b111;
      tick();
      chk("pre_reset_grant_seen", 64'(rf_w_valid), 64'd1);
      rst_n = 1'b0;
      tick();
      chk("midreset_rf_valid", 64'(rf_w_valid), 64'd0);
      chk("midreset_pend", 64'(pend_o), 64'd0);
      rst_n = 1'b1;
      #1;
      chk("postreset_grant", 64'(wb_ready), 64'b001);
      tick();
      chk("postreset_rf_ad", 64'(rf_w_ad), 64'd20);
      chk("postreset_rf_data", 64'(rf_w_data), 64'h2020_2020);
      wb_valid = 3'b000;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/wb_scoreboard_arbiter.md
Name: wb_scoreboard_arbiter

Overview:
Sits between the issue stage, the writeback sources (ALU, LSU, MUL/DIV) and the register file's single write port. Holds a 32-entry pending-write scoreboard and stalls issue on RAW/WAW hazards. Arbitrates NUM_WB writeback requesters onto the register-file write port using round-robin, with a registered output.

Parameters:
NUM_WB, 3, number of writeback requesters (2..8)
xlen, from cpu_parameters (32), data width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
flush  in  1  pipeline flush; clears scoreboard
iss_valid  in  1  instruction presented for issue
iss_rs1_valid  in  1  rs1 used
iss_rs1  in  5  rs1 index
iss_rs2_valid  in  1  rs2 used
iss_rs2  in  5  rs2 index
iss_rd_valid  in  1  instruction writes rd
iss_rd  in  5  rd index
iss_ready  out  1  no hazard; issue fires when iss_valid && iss_ready
wb_valid  in  NUM_WB  writeback request per source
wb_ad  in  NUM_WB*5  destination index, source i at [5i+4:5i]
wb_data  in  NUM_WB*xlen  result, source i at [xlen*i +: xlen]
wb_ready  out  NUM_WB  one-hot grant (combinational)
rf_w_valid  out  1  register-file write enable
rf_w_ad  out  5  register-file write index
rf_w_data  out  xlen  register-file write data
pend_o  out  32  scoreboard state, for debug

Behaviour:
- Reset (rst_n=0 at posedge): pend=0, rr_ptr=0, rf_w_valid=0, rf_w_ad=0, rf_w_data=0. Reset mid-transfer drops any in-flight write.
- pend[0] is constant 0; an issue or writeback to x0 never sets it.
- iss_ready is combinational from registered pend only. There is no same-cycle bypass of a clearing writeback.
- iss_ready = !flush && !(rs1_valid && pend[rs1]) && !(rs2_valid && pend[rs2]) && !(rd_valid && pend[rd]).
- WAW stall guarantees at most one outstanding write per register.
- Issue fire with rd_valid and rd!=0: pend[rd] <= 1 at the next edge.
- Arbitration is round-robin. Search wb_valid starting at index rr_ptr, wrapping modulo NUM_WB; the first set bit wins.
- wb_ready has at most one bit set, and is 0 when no wb_valid bit is set.
- A source holds wb_valid/wb_ad/wb_data stable until wb_ready=1. The transfer occurs in the cycle where both are high.
- On grant of source g: rr_ptr <= (g+1) mod NUM_WB. With no grant, rr_ptr holds.
- Write latency is 1 cycle. At the edge after grant: rf_w_valid<=1, rf_w_ad<=wb_ad[g], rf_w_data<=wb_data[g], pend[wb_ad[g]]<=0.
- With no grant: rf_w_valid<=0, and rf_w_ad/rf_w_data hold.
- Writeback to x0 is forwarded with rf_w_ad=0; the register file discards it.
- Writeback to a register whose pend bit is already 0 is forwarded normally; its clear is a no-op.
- Issue-set and writeback-clear of the same index in one cycle: set wins, pend=1.
- flush=1: pend <= 0 at the next edge, overriding any issue-set, and iss_ready=0 that cycle.
- Writeback arbitration and the register-file write continue unchanged during flush. rr_ptr is unaffected.
- Throughput: one register-file write per cycle sustained. With all sources requesting continuously, each is granted once every NUM_WB cycles.

Test Plan:
- Reset then idle -> pend_o=0, rf_w_valid=0, iss_ready=1 for iss rs1=5, rs2=6, rd=7.
- Issue rd=7; next cycle issue rs1=7 -> iss_ready=0. Source 1 writes ad=7, data=0xDEADBEEF -> next cycle rf_w_valid=1, rf_w_ad=7, rf_w_data=0xDEADBEEF, pend[7]=0, iss_ready=1.
- NUM_WB=3, all wb_valid held high for 6 cycles from reset -> grants 0,1,2,0,1,2 and rf_w_ad follows each source's ad.
- Issue rd=0 with rs1=0 -> pend_o stays 0 and subsequent rd=0 issues never stall.
- Issue rd=3 and rd=9; assert flush one cycle -> pend_o=0 next cycle, iss_ready=0 during the flush cycle. A concurrent wb grant of ad=3 still produces rf_w_valid=1, rf_w_ad=3.
- Issue rd=4 in the same cycle as a writeback grant for ad=4 while pend[4]=0 -> pend[4]=1 afterwards (set wins).
- Assert rst_n=0 while wb_valid=3'b111 -> the next edge gives rf_w_valid=0 and rr_ptr=0. After release, source 0 is granted first.
